// File: rtl/decode_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module  : decode_operand_fetch
// Brief   : Pipeline stage 2. Decodes, reads the owned register file, issues
//           registered fields with forwarding flags, stalls on LOAD, halts on HLT.
// Revision: 1.0
// ============================================================================
module decode_operand_fetch #(
  parameter int NREGS        = 16,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  opcode,
  output logic [3:0]  destReg,
  output logic [15:0] srcVal1,
  output logic [15:0] srcVal2,
  output logic [7:0]  memAddr,
  output logic        used1,
  output logic        used2,
  input  logic        storeNow,
  input  logic [3:0]  destRegStore,
  input  logic [15:0] destVal,
  output logic        storeDone,
  output logic        halted,
  output logic        load_abort
);

  localparam int CW = $clog2(LOAD_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LOAD_TIMEOUT - 1);

  localparam logic [3:0] OP_HLT   = 4'd1;
  localparam logic [3:0] OP_NOT   = 4'd9;
  localparam logic [3:0] OP_LOAD  = 4'd14;
  localparam logic [3:0] OP_STORE = 4'd15;

  localparam logic [1:0] S_RUN       = 2'd0;
  localparam logic [1:0] S_LOAD_WAIT = 2'd1;
  localparam logic [1:0] S_HALT      = 2'd2;

  logic [15:0]   regs_q [NREGS];
  logic [15:0]   regs_d [NREGS];
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] counter_q, counter_d;
  logic [3:0]    load_dest_q, load_dest_d;
  logic          load_abort_q, load_abort_d;
  logic          storeDone_q, storeDone_d;
  logic [3:0]    last_dest_q, last_dest_d;
  logic          last_valid_q, last_valid_d;
  logic [3:0]    opcode_q, opcode_d;
  logic [3:0]    destReg_q, destReg_d;
  logic [15:0]   srcVal1_q, srcVal1_d;
  logic [15:0]   srcVal2_q, srcVal2_d;
  logic [7:0]    memAddr_q, memAddr_d;
  logic          used1_q, used1_d;
  logic          used2_q, used2_d;

  logic [3:0]    op, rd, rs1, rs2, src1_idx;
  logic          accept, load_exit;
  logic          reads_src1, reads_src2, writes_dest;
  logic [15:0]   rd_val1, rd_val2;

  assign op  = instr[15:12];
  assign rd  = instr[11:8];
  assign rs1 = instr[7:4];
  assign rs2 = instr[3:0];
  assign accept = instr_valid & instr_ready;

  // Register file write port, owned here but driven by execute.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    if (storeNow) regs_d[destRegStore] = destVal;
    storeDone_d = storeNow;
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      counter_q    <= '0;
      load_dest_q  <= '0;
      load_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      load_dest_q  <= load_dest_d;
      load_abort_q <= load_abort_d;
    end
  end

  // FSM: next state. A matching write-back beats a simultaneous timeout.
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    load_dest_d  = load_dest_q;
    load_abort_d = 1'b0;
    load_exit    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (accept && op == OP_HLT) begin
          state_d = S_HALT;
        end else if (accept && op == OP_LOAD) begin
          state_d     = S_LOAD_WAIT;
          load_dest_d = rd;
          counter_d   = '0;
        end
      end
      S_LOAD_WAIT: begin
        if (storeNow && destRegStore == load_dest_q) begin
          state_d   = S_RUN;
          counter_d = '0;
          load_exit = 1'b1;
        end else if (counter_q == CNT_LAST) begin
          state_d      = S_RUN;
          counter_d    = '0;
          load_abort_d = 1'b1;
          load_exit    = 1'b1;
        end else begin
          counter_d = counter_q + CW'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RUN;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    instr_ready = (state_q == S_RUN) & ~rst;
    halted      = (state_q == S_HALT);
  end

  // Operand selection with same-cycle write-through from the write port.
  always_comb begin
    reads_src1  = ((op >= 4'd2) && (op <= 4'd10)) || (op == OP_STORE);
    reads_src2  = ((op >= 4'd2) && (op <= 4'd8)) || (op == 4'd10);
    writes_dest = ((op >= 4'd2) && (op <= 4'd10)) || (op == OP_LOAD);
    src1_idx    = (op == OP_STORE) ? rd : rs1;
    rd_val1     = (storeNow && destRegStore == src1_idx) ? destVal : regs_q[src1_idx];
    rd_val2     = (storeNow && destRegStore == rs2) ? destVal : regs_q[rs2];
  end

  // Issue fields; a cycle without accept issues an all-zero bubble.
  always_comb begin
    opcode_d     = '0;
    destReg_d    = '0;
    srcVal1_d    = '0;
    srcVal2_d    = '0;
    memAddr_d    = '0;
    used1_d      = 1'b0;
    used2_d      = 1'b0;
    last_dest_d  = last_dest_q;
    last_valid_d = last_valid_q;
    if (accept) begin
      opcode_d  = op;
      destReg_d = rd;
      srcVal1_d = rd_val1;
      if (op != OP_NOT && op != OP_LOAD && op != OP_STORE) srcVal2_d = rd_val2;
      if (op == OP_LOAD || op == OP_STORE) memAddr_d = instr[7:0];
      used1_d = last_valid_q & reads_src1 & (src1_idx == last_dest_q);
      used2_d = last_valid_q & reads_src2 & (rs2 == last_dest_q);
      if (writes_dest) begin
        last_dest_d  = rd;
        last_valid_d = 1'b1;
      end
    end
    if (load_exit) last_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      storeDone_q  <= 1'b0;
      last_dest_q  <= '0;
      last_valid_q <= 1'b0;
      opcode_q     <= '0;
      destReg_q    <= '0;
      srcVal1_q    <= '0;
      srcVal2_q    <= '0;
      memAddr_q    <= '0;
      used1_q      <= 1'b0;
      used2_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      storeDone_q  <= storeDone_d;
      last_dest_q  <= last_dest_d;
      last_valid_q <= last_valid_d;
      opcode_q     <= opcode_d;
      destReg_q    <= destReg_d;
      srcVal1_q    <= srcVal1_d;
      srcVal2_q    <= srcVal2_d;
      memAddr_q    <= memAddr_d;
      used1_q      <= used1_d;
      used2_q      <= used2_d;
    end
  end

  assign opcode     = opcode_q;
  assign destReg    = destReg_q;
  assign srcVal1    = srcVal1_q;
  assign srcVal2    = srcVal2_q;
  assign memAddr    = memAddr_q;
  assign used1      = used1_q;
  assign used2      = used2_q;
  assign storeDone  = storeDone_q;
  assign load_abort = load_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_decode_operand_fetch
// Brief   : Vector table, directed multi-cycle sequences and random traffic
//           checked against a behavioural model of the decode stage.
// Revision: 1.0
// ============================================================================
module tb_decode_operand_fetch;

  localparam int LOAD_TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  opcode, destReg;
  logic [15:0] srcVal1, srcVal2;
  logic [7:0]  memAddr;
  logic        used1, used2;
  logic        storeNow = 1'b0;
  logic [3:0]  destRegStore = '0;
  logic [15:0] destVal = '0;
  logic        storeDone, halted, load_abort;

  int checks = 0;
  int errors = 0;

  decode_operand_fetch #(.NREGS(16), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .opcode(opcode), .destReg(destReg),
    .srcVal1(srcVal1), .srcVal2(srcVal2), .memAddr(memAddr),
    .used1(used1), .used2(used2), .storeNow(storeNow),
    .destRegStore(destRegStore), .destVal(destVal), .storeDone(storeDone),
    .halted(halted), .load_abort(load_abort)
  );

  always #5 clk = ~clk;

  // Behavioural model state: architectural registers plus stall/halt status.
  logic [15:0] m_regs [16];
  bit          m_halted = 0, m_pending = 0;
  int          m_wait = 0, m_last = -1, m_load_dest = 0;
  logic [3:0]  e_op, e_dest;
  logic [15:0] e_s1, e_s2;
  logic [7:0]  e_mem;
  bit          e_u1, e_u2, e_sd, e_halted, e_abort;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 60) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input int a, input bit sn, input logic [3:0] dr,
                                         input logic [15:0] dv);
    return (sn && int'(dr) == a) ? dv : m_regs[a];
  endfunction

  task automatic model_step(input bit r, input bit v, input logic [15:0] ins, input bit sn,
                            input logic [3:0] dr, input logic [15:0] dv);
    int op, rd, s1, s2, src1;
    bit acc;
    e_op = 0; e_dest = 0; e_s1 = 0; e_s2 = 0; e_mem = 0;
    e_u1 = 0; e_u2 = 0; e_sd = 0; e_abort = 0;
    if (r) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_halted = 0; m_pending = 0; m_wait = 0; m_last = -1; m_load_dest = 0;
      e_halted = 0;
      return;
    end
    op = int'(ins[15:12]); rd = int'(ins[11:8]); s1 = int'(ins[7:4]); s2 = int'(ins[3:0]);
    acc = v && !m_halted && !m_pending;
    e_sd = sn;
    if (acc) begin
      src1   = (op == 15) ? rd : s1;
      e_op   = 4'(op);
      e_dest = 4'(rd);
      e_s1   = m_read(src1, sn, dr, dv);
      e_s2   = (op inside {9, 14, 15}) ? 16'h0 : m_read(s2, sn, dr, dv);
      if (op inside {14, 15}) e_mem = ins[7:0];
      e_u1 = (op inside {[2:10], 15}) && (m_last == src1);
      e_u2 = (op inside {[2:8], 10}) && (m_last == s2);
      if (op inside {[2:10], 14}) m_last = rd;
      if (op == 1) m_halted = 1;
      if (op == 14) begin m_pending = 1; m_wait = 0; m_load_dest = rd; end
    end else if (m_pending) begin
      m_wait++;
      if (sn && int'(dr) == m_load_dest) begin
        m_pending = 0; m_last = -1;
      end else if (m_wait == LOAD_TIMEOUT) begin
        m_pending = 0; m_last = -1; e_abort = 1;
      end
    end
    if (sn) m_regs[dr] = dv;
    e_halted = m_halted;
  endtask

  // One clock: drive, check ready before the edge, then check issued fields after it.
  task automatic cycle(input bit r, input bit v, input logic [15:0] ins, input bit sn,
                       input logic [3:0] dr, input logic [15:0] dv);
    rst = r; instr_valid = v; instr = ins; storeNow = sn; destRegStore = dr; destVal = dv;
    #1;
    chk("instr_ready", {31'b0, instr_ready}, {31'b0, !r && !m_halted && !m_pending});
    model_step(r, v, ins, sn, dr, dv);
    @(posedge clk); #1;
    chk("opcode",     {28'b0, opcode},     {28'b0, e_op});
    chk("destReg",    {28'b0, destReg},    {28'b0, e_dest});
    chk("srcVal1",    {16'b0, srcVal1},    {16'b0, e_s1});
    chk("srcVal2",    {16'b0, srcVal2},    {16'b0, e_s2});
    chk("memAddr",    {24'b0, memAddr},    {24'b0, e_mem});
    chk("used1",      {31'b0, used1},      {31'b0, e_u1});
    chk("used2",      {31'b0, used2},      {31'b0, e_u2});
    chk("storeDone",  {31'b0, storeDone},  {31'b0, e_sd});
    chk("halted",     {31'b0, halted},     {31'b0, e_halted});
    chk("load_abort", {31'b0, load_abort}, {31'b0, e_abort});
  endtask

  typedef struct {
    bit r; bit v; logic [15:0] ins; bit sn; logic [3:0] dr; logic [15:0] dv;
    logic [3:0] op; logic [15:0] s1; logic [15:0] s2; bit u1; bit u2; bit sd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n;
    logic [3:0] o;
    vecs[0] = '{1, 0, 16'h0000, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 16'h0000, 0, 0, 0};
    vecs[1] = '{0, 0, 16'h0000, 1, 4'h1, 16'h0005, 4'h0, 16'h0000, 16'h0000, 0, 0, 1};
    vecs[2] = '{0, 0, 16'h0000, 1, 4'h2, 16'h0007, 4'h0, 16'h0000, 16'h0000, 0, 0, 1};
    vecs[3] = '{0, 1, 16'h2312, 0, 4'h0, 16'h0000, 4'h2, 16'h0005, 16'h0007, 0, 0, 0};
    vecs[4] = '{0, 1, 16'h3431, 0, 4'h0, 16'h0000, 4'h3, 16'h0000, 16'h0005, 1, 0, 0};
    vecs[5] = '{0, 1, 16'h2612, 1, 4'h2, 16'h0009, 4'h2, 16'h0005, 16'h0009, 0, 0, 1};
    vecs[6] = '{0, 0, 16'h0000, 0, 4'h0, 16'h0000, 4'h0, 16'h0000, 16'h0000, 0, 0, 0};

    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].r, vecs[i].v, vecs[i].ins, vecs[i].sn, vecs[i].dr, vecs[i].dv);
      chk($sformatf("vec%0d_opcode", i), {28'b0, opcode}, {28'b0, vecs[i].op});
      chk($sformatf("vec%0d_srcVal1", i), {16'b0, srcVal1}, {16'b0, vecs[i].s1});
      chk($sformatf("vec%0d_srcVal2", i), {16'b0, srcVal2}, {16'b0, vecs[i].s2});
      chk($sformatf("vec%0d_used", i), {30'b0, used1, used2}, {30'b0, vecs[i].u1, vecs[i].u2});
      chk($sformatf("vec%0d_storeDone", i), {31'b0, storeDone}, {31'b0, vecs[i].sd});
    end

    // LOAD R5,0x20 stalls until the write-back to R5 lands.
    cycle(0, 1, 16'hE520, 0, 4'h0, 16'h0);
    chk("load_opcode", {28'b0, opcode}, 32'd14);
    chk("load_memAddr", {24'b0, memAddr}, 32'h20);
    chk("load_stall_ready", {31'b0, instr_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 16'h2755, (i == 1), 4'h6, 16'h0042);
      chk("load_wait_nop", {28'b0, opcode}, 32'd0);
    end
    cycle(0, 1, 16'h2755, 1, 4'h5, 16'h1234);
    chk("load_release_ready", {31'b0, instr_ready}, 32'd1);
    cycle(0, 1, 16'h2755, 0, 4'h0, 16'h0);
    chk("after_load_srcVal1", {16'b0, srcVal1}, 32'h1234);
    chk("after_load_used1", {31'b0, used1}, 32'd0);

    // LOAD with no write-back: abort after exactly LOAD_TIMEOUT waiting cycles.
    cycle(0, 1, 16'hE833, 0, 4'h0, 16'h0);
    n = 0;
    while (n < 100 && !load_abort) begin
      cycle(0, 0, 16'h0, 0, 4'h0, 16'h0);
      n++;
    end
    chk("timeout_cycles", n, LOAD_TIMEOUT);
    chk("timeout_ready", {31'b0, instr_ready}, 32'd1);
    cycle(0, 0, 16'h0, 0, 4'h0, 16'h0);
    chk("abort_one_cycle", {31'b0, load_abort}, 32'd0);

    // HLT is issued once; later instructions are never accepted, writes still are.
    cycle(0, 1, 16'h1000, 0, 4'h0, 16'h0);
    chk("hlt_opcode", {28'b0, opcode}, 32'd1);
    chk("hlt_halted", {31'b0, halted}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 16'h2312, 0, 4'h0, 16'h0);
      chk("halt_nop", {28'b0, opcode}, 32'd0);
      chk("halt_ready", {31'b0, instr_ready}, 32'd0);
    end
    cycle(0, 1, 16'h2312, 1, 4'h9, 16'hABCD);
    chk("halt_storeDone", {31'b0, storeDone}, 32'd1);
    cycle(1, 1, 16'h2312, 1, 4'h9, 16'h5555);
    cycle(0, 1, 16'h2A90, 0, 4'h0, 16'h0);
    chk("post_rst_opcode", {28'b0, opcode}, 32'd2);
    chk("post_rst_srcVal1", {16'b0, srcVal1}, 32'd0);
    chk("post_rst_halted", {31'b0, halted}, 32'd0);

    // Random traffic on a narrow register window to exercise forwarding hits.
    for (int i = 0; i < 2000; i++) begin
      o = 4'($urandom_range(0, 15));
      if (o == 4'd1 && $urandom_range(0, 7) != 0) o = 4'd2;
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
            {o, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
